// File: rtl/sync_fifo_prog_pkg.sv
// Shared definitions for the programmable synchronous FIFO.
// Holds parameter defaults, the read-mode enum and the default-depth count type.
// Imported by the FIFO top and its storage array.
package sync_fifo_prog_pkg;

  localparam int FIFO_WIDTH_DEF = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  // Read mode; the FWFT parameter of the top maps onto this.
  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Occupancy type for the default depth (0..FIFO_DEPTH_DEF inclusive).
  localparam int CNT_W_DEF = $clog2(FIFO_DEPTH_DEF + 1);
  typedef logic [CNT_W_DEF-1:0] fifo_cnt_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port register array used as FIFO storage.
// Latency: write lands at the clock edge; read is combinational from the address.
// Backpressure: none; the caller only writes accepted words. Contents are not reset.
module fifo_ram
  import sync_fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [FIFO_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [FIFO_WIDTH-1:0] rdata_o
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  // Store an accepted word; addresses never exceed FIFO_DEPTH-1.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with arbitrary depth, STD/FWFT read, programmable thresholds, flush.
// Latency: STD read data one cycle after rd_en; FWFT head visible the cycle after the write.
// Backpressure: full rejects writes unless a read is accepted the same cycle; status is registered.
module sync_fifo_prog
  import sync_fifo_prog_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int FWFT       = 0,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  input  logic [CNT_W-1:0]      afull_thr,
  input  logic [CNT_W-1:0]      aempty_thr,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic [1:0]            err_sticky
);

  localparam int                 PTR_W    = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]   DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam fifo_mode_e         MODE     = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  wr_ack_q, wr_ack_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [1:0]            sticky_q, sticky_d;
  logic                  rvld_q, rvld_d;
  logic [FIFO_WIDTH-1:0] dout_q, dout_d;
  logic [FIFO_WIDTH-1:0] ram_rdata;
  logic                  rd_acc, wr_acc, wr_do, rd_do;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almostfull  = (count_q >= afull_thr);
  assign almostempty = (count_q <= aempty_thr);
  assign count       = count_q;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  // Flush overrides any request made alongside it.
  assign wr_do  = wr_acc && !flush;
  assign rd_do  = rd_acc && !flush;

  fifo_ram #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_do),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  // Next-state for pointers, occupancy, status pulses and the registered read port.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    wr_ack_d = wr_do;
    ovf_d    = !flush && wr_en && !wr_acc;
    unf_d    = !flush && rd_en && !rd_acc;
    sticky_d = sticky_q | {ovf_d, unf_d};
    rvld_d   = rd_do;
    dout_d   = rd_do ? ram_rdata : dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      sticky_d = '0;
    end else begin
      if (wr_do) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_do) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_do, rd_do})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_ack_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      sticky_q <= 2'b00;
      rvld_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_ack_q <= wr_ack_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      sticky_q <= sticky_d;
      rvld_q   <= rvld_d;
      dout_q   <= dout_d;
    end
  end

  assign wr_ack     = wr_ack_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign err_sticky = sticky_q;
  // FWFT drives zero while empty so stale, unreset storage never reaches the port.
  assign data_out   = (MODE == FIFO_FWFT) ? (empty ? '0 : ram_rdata) : dout_q;
  assign rd_valid   = (MODE == FIFO_FWFT) ? !empty : rvld_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a depth-6 standard-mode and a depth-6 FWFT instance share stimulus.
// A queue-based model predicts occupancy, flags, status pulses and read data each cycle.
// Directed sequences pin the model with literal values; a random burst exercises wrap.
module tb_sync_fifo_prog;

  localparam int W  = 16;
  localparam int D  = 6;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic [CW-1:0] afull_thr = CW'(D), aempty_thr = '0;

  logic [W-1:0]  s_data_out, f_data_out;
  logic          s_rd_valid, s_full, s_empty, s_af, s_ae, s_ack, s_ovf, s_unf;
  logic          f_rd_valid, f_full, f_empty, f_af, f_ae, f_ack, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;
  logic [1:0]    s_sticky, f_sticky;

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(s_data_out), .rd_valid(s_rd_valid),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr), .full(s_full), .empty(s_empty),
    .almostfull(s_af), .almostempty(s_ae), .count(s_count), .wr_ack(s_ack),
    .overflow(s_ovf), .underflow(s_unf), .err_sticky(s_sticky)
  );

  sync_fifo_prog #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(f_data_out), .rd_valid(f_rd_valid),
    .afull_thr(afull_thr), .aempty_thr(aempty_thr), .full(f_full), .empty(f_empty),
    .almostfull(f_af), .almostempty(f_ae), .count(f_count), .wr_ack(f_ack),
    .overflow(f_ovf), .underflow(f_unf), .err_sticky(f_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] mq [$];
  bit           m_ack = 0, m_ovf = 0, m_unf = 0, m_svld = 0, m_ra, m_wa;
  bit   [1:0]   m_sticky = 2'b00;
  logic [W-1:0] m_sdout = '0;
  bit           chk_en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ack = 0; m_ovf = 0; m_unf = 0; m_svld = 0; m_sticky = 2'b00; m_sdout = '0;
    end else if (flush) begin
      mq.delete();
      m_ack = 0; m_ovf = 0; m_unf = 0; m_svld = 0; m_sticky = 2'b00;
    end else begin
      m_ra = rd_en && (mq.size() > 0);
      m_wa = wr_en && ((mq.size() < D) || m_ra);
      if (m_ra) m_sdout = mq.pop_front();
      if (m_wa) mq.push_back(data_in);
      m_svld   = m_ra;
      m_ack    = m_wa;
      m_ovf    = wr_en && !m_wa;
      m_unf    = rd_en && !m_ra;
      m_sticky = m_sticky | {m_ovf, m_unf};
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_count", 32'(s_count), 32'(mq.size()));
      chk("s_count_range", 32'(s_count <= CW'(D)), 32'd1);
      chk("s_empty", 32'(s_empty), 32'(mq.size() == 0));
      chk("s_full", 32'(s_full), 32'(mq.size() == D));
      chk("s_afull", 32'(s_af), 32'(mq.size() >= int'(afull_thr)));
      chk("s_aempty", 32'(s_ae), 32'(mq.size() <= int'(aempty_thr)));
      chk("s_wr_ack", 32'(s_ack), 32'(m_ack));
      chk("s_overflow", 32'(s_ovf), 32'(m_ovf));
      chk("s_underflow", 32'(s_unf), 32'(m_unf));
      chk("s_err_sticky", 32'(s_sticky), 32'(m_sticky));
      chk("s_rd_valid", 32'(s_rd_valid), 32'(m_svld));
      chk("s_data_out", 32'(s_data_out), 32'(m_sdout));
      chk("f_count", 32'(f_count), 32'(mq.size()));
      chk("f_empty", 32'(f_empty), 32'(mq.size() == 0));
      chk("f_full", 32'(f_full), 32'(mq.size() == D));
      chk("f_afull", 32'(f_af), 32'(mq.size() >= int'(afull_thr)));
      chk("f_aempty", 32'(f_ae), 32'(mq.size() <= int'(aempty_thr)));
      chk("f_wr_ack", 32'(f_ack), 32'(m_ack));
      chk("f_overflow", 32'(f_ovf), 32'(m_ovf));
      chk("f_underflow", 32'(f_unf), 32'(m_unf));
      chk("f_err_sticky", 32'(f_sticky), 32'(m_sticky));
      chk("f_rd_valid", 32'(f_rd_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("f_data_out", 32'(f_data_out), 32'(mq[0]));
    end
  end

  // Apply inputs, let one edge sample them, return 2 time units after that edge.
  task automatic drive(input bit w, input logic [W-1:0] d, input bit r, input bit f);
    wr_en = w; data_in = d; rd_en = r; flush = f;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_count"}, 32'(s_count), 32'd0);
    chk({tag, "_s_empty"}, 32'(s_empty), 32'd1);
    chk({tag, "_s_full"}, 32'(s_full), 32'd0);
    chk({tag, "_s_data_out"}, 32'(s_data_out), 32'd0);
    chk({tag, "_s_rd_valid"}, 32'(s_rd_valid), 32'd0);
    chk({tag, "_s_status"}, 32'({s_ack, s_ovf, s_unf, s_sticky}), 32'd0);
    chk({tag, "_f_count"}, 32'(f_count), 32'd0);
    chk({tag, "_f_empty"}, 32'(f_empty), 32'd1);
    chk({tag, "_f_rd_valid"}, 32'(f_rd_valid), 32'd0);
    chk({tag, "_f_data_out"}, 32'(f_data_out), 32'd0);
    chk({tag, "_f_status"}, 32'({f_ack, f_ovf, f_unf, f_sticky}), 32'd0);
  endtask

  initial begin
    int wprob;
    @(posedge clk);
    #2;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    chk_en = 1;

    // Fill a depth-6 FIFO, overflow once, drain in order.
    for (int i = 1; i <= 6; i++) drive(1, W'(i), 0, 0);
    chk("t1_full", 32'(s_full), 32'd1);
    chk("t1_count6", 32'(s_count), 32'd6);
    drive(1, 16'h0007, 0, 0);
    chk("t1_ovf", 32'(s_ovf), 32'd1);
    chk("t1_ack", 32'(s_ack), 32'd0);
    chk("t1_sticky", 32'(s_sticky), 32'h2);
    for (int i = 1; i <= 6; i++) begin
      drive(0, '0, 1, 0);
      chk("t1_rd_data", 32'(s_data_out), 32'(i));
      chk("t1_rd_valid", 32'(s_rd_valid), 32'd1);
    end
    drive(0, '0, 0, 0);
    chk("t1_rd_valid_drop", 32'(s_rd_valid), 32'd0);
    chk("t1_data_hold", 32'(s_data_out), 32'h6);

    // Empty-FIFO reads.
    drive(0, '0, 0, 1);
    chk("t4_flush_sticky", 32'(s_sticky), 32'd0);
    drive(0, '0, 1, 0);
    chk("t4_unf_a", 32'(s_unf), 32'd1);
    chk("t4_sticky", 32'(s_sticky), 32'h1);
    drive(1, 16'h0011, 1, 0);
    chk("t4_unf_b", 32'(s_unf), 32'd1);
    chk("t4_count1", 32'(s_count), 32'd1);
    chk("t4_ack", 32'(s_ack), 32'd1);
    chk("t4_fwft_head", 32'(f_data_out), 32'h0011);

    // Full FIFO with simultaneous read and write.
    for (int i = 0; i < 5; i++) drive(1, W'(16'h12 + i), 0, 0);
    chk("t3_count6", 32'(s_count), 32'd6);
    drive(1, 16'hBEEF, 1, 0);
    chk("t3_ack", 32'(s_ack), 32'd1);
    chk("t3_ovf", 32'(s_ovf), 32'd0);
    chk("t3_count_hold", 32'(s_count), 32'd6);
    chk("t3_popped", 32'(s_data_out), 32'h0011);
    for (int i = 0; i < 6; i++) begin
      drive(0, '0, 1, 0);
      if (i == 0) chk("t3_first", 32'(s_data_out), 32'h0012);
    end
    chk("t3_last_beef", 32'(s_data_out), 32'hBEEF);
    drive(0, '0, 0, 0);

    // Thresholds and flush with a concurrent write.
    afull_thr = 3'd4; aempty_thr = 3'd2;
    for (int k = 1; k <= 4; k++) begin
      drive(1, W'(16'h40 + k), 0, 0);
      if (k == 2) begin
        chk("t5_ae_at2", 32'(s_ae), 32'd1);
        chk("t5_af_at2", 32'(s_af), 32'd0);
      end
      if (k == 3) chk("t5_ae_at3", 32'(s_ae), 32'd0);
    end
    chk("t5_af_at4", 32'(s_af), 32'd1);
    afull_thr = 3'd0;
    #1 chk("t5_af_thr0", 32'(s_af), 32'd1);
    afull_thr = 3'd7;
    #1 chk("t5_af_thr7", 32'(s_af), 32'd0);
    afull_thr = 3'd4;
    drive(1, 16'h0055, 0, 1);
    chk("t5_flush_count", 32'(s_count), 32'd0);
    chk("t5_flush_empty", 32'(s_empty), 32'd1);
    chk("t5_flush_sticky", 32'(s_sticky), 32'd0);
    chk("t5_flush_ack", 32'(s_ack), 32'd0);

    // FWFT fall-through and pop.
    drive(1, 16'h00AA, 0, 0);
    chk("t6_fwft_data", 32'(f_data_out), 32'h00AA);
    chk("t6_fwft_valid", 32'(f_rd_valid), 32'd1);
    drive(0, '0, 1, 0);
    chk("t6_fwft_empty", 32'(f_empty), 32'd1);
    chk("t6_fwft_valid0", 32'(f_rd_valid), 32'd0);

    // Random traffic across several occupancy biases, with rare flushes.
    for (int c = 0; c < 300; c++) begin
      wprob = (c < 100) ? 75 : ((c < 200) ? 25 : 50);
      if (c % 25 == 0) begin
        afull_thr  = CW'($urandom_range(0, 7));
        aempty_thr = CW'($urandom_range(0, 7));
      end
      drive($urandom_range(0, 99) < wprob, W'($urandom),
            $urandom_range(0, 99) < (100 - wprob), $urandom_range(0, 59) == 0);
    end

    // Asynchronous reset in the middle of a burst.
    drive(0, '0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, W'(16'h0C0 + i), 0, 0);
    drive(1, 16'h00C3, 1, 0);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    wr_en = 0; rd_en = 0; flush = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 30; c++)
      drive($urandom_range(0, 1) == 1, W'($urandom), $urandom_range(0, 1) == 1, 0);
    drive(0, '0, 0, 0);
    @(negedge clk);
    #1;
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
